// File: rtl/riego_pkg.sv
// Shared types for the multi-channel irrigation controller: channel FSM states
// and the per-plant-type humidity threshold table (indexed by tipo).
package riego_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PEND  = 3'd1,
        WATER = 3'd2,
        SOAK  = 3'd3,
        FAULT = 3'd4
    } ch_state_t;

    localparam int TH_W        = 16;
    localparam int SOAK_W      = 16;
    localparam int ALARM_PULSE = 500;

    // Below umbral_bajo the plant asks for water; at or above umbral_alto it is done.
    localparam logic [TH_W-1:0] UMBRAL_BAJO [16] = '{0: 16'd1200, 1: 16'd800,  default: 16'd1000};
    localparam logic [TH_W-1:0] UMBRAL_ALTO [16] = '{0: 16'd2000, 1: 16'd1500, default: 16'd1800};

endpackage

// File: rtl/rr_arbitro.sv
// Round-robin arbiter with one-hot grant; the search starts just after the
// last granted index, which is also exported as a binary index.
module rr_arbitro #(
    parameter int N_CH = 4,
    parameter int PW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] req,
    output logic [N_CH-1:0] gnt,
    output logic [PW-1:0]   idx
);

    logic [PW-1:0]     ptr;
    logic [PW-1:0]     start;
    logic [N_CH-1:0]   rot;
    logic [N_CH-1:0]   rot_gnt;
    logic [2*N_CH-1:0] rot_back;

    assign start = (ptr == PW'(N_CH - 1)) ? '0 : ptr + PW'(1);

    // Rotate so the search origin sits at bit 0, keep the lowest request, rotate back.
    assign rot      = N_CH'({req, req} >> start);
    assign rot_gnt  = rot & (-rot);
    assign rot_back = {rot_gnt, rot_gnt} << start;
    assign gnt      = rot_back[2*N_CH-1:N_CH];

    always_comb begin
        idx = '0;
        for (int k = 0; k < N_CH; k++)
            if (gnt[k]) idx = PW'(k);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    ptr <= PW'(N_CH - 1);
        else if (|gnt) ptr <= idx;
    end

endmodule

// File: rtl/riego_multicanal.sv
// Multi-channel irrigation controller: one FSM per plant channel, a single pump
// slot shared round-robin. Define RIEGO_ALARMA_EN to build the alarm output.
module riego_multicanal
    import riego_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int HUM_W    = 12,
    parameter int T_MAX_ON = 30000,
    parameter int T_SOAK   = 60000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             habilitar,
    input  logic             dato_valid,
    input  logic [2:0]       dato_canal,
    input  logic [HUM_W-1:0] dato_humedad,
    input  logic [3:0]       dato_tipo,
    input  logic             ack_fallo,
    output logic [N_CH-1:0]  activarB,
    output logic             regando,
    output logic [2:0]       canal_activo,
    output logic [N_CH-1:0]  fallo,
    output logic             alarma
);

    localparam int TON_W = $clog2(T_MAX_ON + 1);
    localparam int PW    = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]  req;
    logic [N_CH-1:0]  req_en;
    logic [N_CH-1:0]  gnt;
    logic [PW-1:0]    gnt_idx;
    logic [TON_W-1:0] ton_q;
    logic [2:0]       canal_q;
    logic             timeout;
    logic             new_wet;

    assign regando      = |activarB;
    assign canal_activo = canal_q;
    assign timeout      = (ton_q >= TON_W'(T_MAX_ON));
    // An incoming sample already wet enough clears a fault without waiting for ack.
    assign new_wet      = (32'(dato_humedad) >= 32'(UMBRAL_ALTO[dato_tipo]));
    // Grants only while enabled and with the pump slot free.
    assign req_en       = req & {N_CH{habilitar && !regando}};

    rr_arbitro #(.N_CH(N_CH), .PW(PW)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_en),
        .gnt   (gnt),
        .idx   (gnt_idx)
    );

    // Single on-time counter: only one channel can be watering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ton_q   <= '0;
            canal_q <= '0;
        end else if (|gnt) begin
            ton_q   <= '0;
            canal_q <= 3'(gnt_idx);
        end else if (tick && regando && ton_q != '1) begin
            ton_q   <= ton_q + TON_W'(1);
        end
    end

`ifdef RIEGO_ALARMA_EN
    logic [N_CH-1:0] fault_entry;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ch_state_t         state_q, state_d;
        logic [HUM_W-1:0]  hum_q;
        logic [3:0]        tipo_q;
        logic [SOAK_W-1:0] soak_q;
        logic              act_q, flt_q;
        logic              sel, seco, mojado;

        assign sel    = dato_valid && (dato_canal == 3'(i));
        assign seco   = (32'(hum_q) < 32'(UMBRAL_BAJO[tipo_q]));
        assign mojado = (32'(hum_q) >= 32'(UMBRAL_ALTO[tipo_q]));
        assign req[i] = (state_q == PEND) && seco;

        always_comb begin
            state_d = state_q;
            case (state_q)
                IDLE:    if (seco) state_d = PEND;
                PEND:    if (gnt[i])     state_d = WATER;
                         else if (!seco) state_d = IDLE;
                WATER:   if (timeout)         state_d = FAULT;
                         else if (!habilitar) state_d = IDLE;
                         else if (mojado)     state_d = SOAK;
                SOAK:    if (soak_q >= SOAK_W'(T_SOAK)) state_d = IDLE;
                FAULT:   if (ack_fallo || (sel && new_wet)) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= IDLE;
                hum_q   <= '0;
                tipo_q  <= '0;
                soak_q  <= '0;
                act_q   <= 1'b0;
                flt_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                act_q   <= (state_d == WATER);
                flt_q   <= (state_d == FAULT);
                if (sel) begin
                    hum_q  <= dato_humedad;
                    tipo_q <= dato_tipo;
                end
                // Held at zero outside SOAK so every soak starts from a clean count.
                if (state_q != SOAK)             soak_q <= '0;
                else if (tick && soak_q != '1)   soak_q <= soak_q + SOAK_W'(1);
            end
        end

        assign activarB[i] = act_q;
        assign fallo[i]    = flt_q;
`ifdef RIEGO_ALARMA_EN
        assign fault_entry[i] = (state_d == FAULT) && (state_q != FAULT);
`endif
    end

`ifdef RIEGO_ALARMA_EN
    localparam int PULSE_W = $clog2(ALARM_PULSE + 1);

    logic               alarm_flt;
    logic [PULSE_W-1:0] pulse_q;

    // A fault entering on the same edge as ack keeps the alarm latched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_flt <= 1'b0;
            pulse_q   <= '0;
        end else begin
            if (|fault_entry)   alarm_flt <= 1'b1;
            else if (ack_fallo) alarm_flt <= 1'b0;
            if (|gnt)                        pulse_q <= PULSE_W'(ALARM_PULSE);
            else if (tick && pulse_q != '0)  pulse_q <= pulse_q - PULSE_W'(1);
        end
    end

    assign alarma = alarm_flt || (pulse_q != '0);
`else
    assign alarma = 1'b0;
`endif

endmodule

// File: tb/tb_riego_multicanal.sv
// Directed scoreboard bench for riego_multicanal (shortened on/soak times so the
// run stays short); alarm expectations follow RIEGO_ALARMA_EN.
module tb_riego_multicanal;

    localparam int N_CH     = 4;
    localparam int HUM_W    = 12;
    localparam int T_MAX_ON = 600;
    localparam int T_SOAK   = 800;
`ifdef RIEGO_ALARMA_EN
    localparam logic ALARM_ON = 1'b1;
`else
    localparam logic ALARM_ON = 1'b0;
`endif

    typedef struct packed {
        logic [N_CH-1:0] act;
        logic [N_CH-1:0] flt;
        logic [2:0]      canal;
        logic            rg;
    } obs_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             tick = 1'b0;
    logic             habilitar = 1'b0;
    logic             dato_valid = 1'b0;
    logic [2:0]       dato_canal = '0;
    logic [HUM_W-1:0] dato_humedad = '0;
    logic [3:0]       dato_tipo = '0;
    logic             ack_fallo = 1'b0;
    logic [N_CH-1:0]  activarB;
    logic             regando;
    logic [2:0]       canal_activo;
    logic [N_CH-1:0]  fallo;
    logic             alarma;

    obs_t sbq[$];
    obs_t e;
    int   n_vec = 0;
    int   n_err = 0;

    riego_multicanal #(
        .N_CH(N_CH), .HUM_W(HUM_W), .T_MAX_ON(T_MAX_ON), .T_SOAK(T_SOAK)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .habilitar    (habilitar),
        .dato_valid   (dato_valid),
        .dato_canal   (dato_canal),
        .dato_humedad (dato_humedad),
        .dato_tipo    (dato_tipo),
        .ack_fallo    (ack_fallo),
        .activarB     (activarB),
        .regando      (regando),
        .canal_activo (canal_activo),
        .fallo        (fallo),
        .alarma       (alarma)
    );

    always #5 clk = ~clk;

    function automatic obs_t obs();
        return {activarB, fallo, canal_activo, regando};
    endfunction

    function automatic obs_t mk(input logic [N_CH-1:0] a, input logic [N_CH-1:0] f,
                                input int c, input logic r);
        return {a, f, 3'(c), r};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sample(input int ch, input int hum, input int tipo);
        dato_valid   = 1'b1;
        dato_canal   = 3'(ch);
        dato_humedad = HUM_W'(hum);
        dato_tipo    = 4'(tipo);
        cyc(1);
        dato_valid   = 1'b0;
    endtask

    // Reset, then mark every channel wet while disabled so nothing waters by itself.
    task automatic do_reset();
        habilitar = 1'b0; tick = 1'b1; ack_fallo = 1'b0; dato_valid = 1'b0;
        rst_n = 1'b0;
        sbq.delete();
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        for (int c = 0; c < N_CH; c++) sample(c, 2000, 0);
        cyc(1);
        habilitar = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; habilitar = 1'b1; tick = 1'b1;
        sbq.push_back(mk('0, '0, 0, 1'b0));
        cyc(2);
        e = sbq.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL reset_outputs: got %h want %h", obs(), e); end
        n_vec++;
        if (alarma !== 1'b0) begin n_err++; $display("FAIL reset_alarma: got %b want 0", alarma); end
    endtask

    task automatic test_basic();
        do_reset();
        sample(2, 1000, 0);
        sbq.push_back(mk(4'b0000, '0, 0, 1'b0));
        cyc(1);
        e = sbq.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL basic_pend: got %h want %h", obs(), e); end
        sbq.push_back(mk(4'b0100, '0, 2, 1'b1));
        cyc(1);
        e = sbq.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL basic_water: got %h want %h", obs(), e); end
        n_vec++;
        if (alarma !== ALARM_ON) begin n_err++; $display("FAIL basic_alarma: got %b want %b", alarma, ALARM_ON); end
        sample(2, 2000, 0);
        sbq.push_back(mk(4'b0000, '0, 2, 1'b0));
        cyc(1);
        e = sbq.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL basic_soak: got %h want %h", obs(), e); end
    endtask

    task automatic test_rr();
        do_reset();
        habilitar = 1'b0;
        sample(3, 500, 1);
        sample(0, 500, 1);
        cyc(2);
        sbq.push_back(mk(4'b0000, '0, 0, 1'b0));
        e = sbq.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL rr_hold_disabled: got %h want %h", obs(), e); end
        habilitar = 1'b1;
        sbq.push_back(mk(4'b0001, '0, 0, 1'b1));
        cyc(1);
        e = sbq.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL rr_first_ch0: got %h want %h", obs(), e); end
        sample(0, 1500, 1);
        sbq.push_back(mk(4'b0000, '0, 0, 1'b0));
        cyc(1);
        e = sbq.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL rr_gap: got %h want %h", obs(), e); end
        sbq.push_back(mk(4'b1000, '0, 3, 1'b1));
        cyc(1);
        e = sbq.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL rr_second_ch3: got %h want %h", obs(), e); end
    endtask

    task automatic test_enable_and_reset();
        do_reset();
        sample(2, 1000, 0);
        sbq.push_back(mk(4'b0100, '0, 2, 1'b1));
        cyc(2);
        e = sbq.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL en_water: got %h want %h", obs(), e); end
        habilitar = 1'b0;
        sbq.push_back(mk(4'b0000, '0, 2, 1'b0));
        cyc(1);
        e = sbq.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL en_off_one_cycle: got %h want %h", obs(), e); end
        sbq.push_back(mk(4'b0000, '0, 2, 1'b0));
        cyc(3);
        e = sbq.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL en_no_grant: got %h want %h", obs(), e); end
        habilitar = 1'b1;
        sbq.push_back(mk(4'b0100, '0, 2, 1'b1));
        cyc(1);
        e = sbq.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL en_regrant: got %h want %h", obs(), e); end
        #2 rst_n = 1'b0;
        sbq.push_back(mk(4'b0000, '0, 0, 1'b0));
        #1;
        e = sbq.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL async_reset: got %h want %h", obs(), e); end
    endtask

    task automatic test_bad_channel();
        do_reset();
        sample(6, 100, 0);
        sbq.push_back(mk(4'b0000, '0, 0, 1'b0));
        cyc(3);
        e = sbq.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL bad_channel: got %h want %h", obs(), e); end
    endtask

    task automatic test_soak();
        int k;
        do_reset();
        sample(1, 1000, 0);
        sbq.push_back(mk(4'b0010, '0, 1, 1'b1));
        cyc(2);
        e = sbq.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL soak_pre_water: got %h want %h", obs(), e); end
        sample(1, 2000, 0);
        sbq.push_back(mk(4'b0000, '0, 1, 1'b0));
        cyc(1);
        e = sbq.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL soak_enter: got %h want %h", obs(), e); end
        sample(1, 100, 0);
        k = 1;
        while (activarB[1] !== 1'b1 && k < T_SOAK + 50) begin cyc(1); k++; end
        n_vec++;
        if (k <= T_SOAK || k > T_SOAK + 4) begin
            n_err++; $display("FAIL soak_hold: pump back after %0d cycles, want %0d..%0d", k, T_SOAK + 1, T_SOAK + 4);
        end
        sbq.push_back(mk(4'b0010, '0, 1, 1'b1));
        e = sbq.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL soak_rewater: got %h want %h", obs(), e); end
    endtask

    task automatic test_fault();
        int k;
        do_reset();
        tick = 1'b0;
        sample(1, 1000, 0);
        sbq.push_back(mk(4'b0010, '0, 1, 1'b1));
        cyc(1 + T_MAX_ON + 20);
        e = sbq.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL fault_tick_gated: got %h want %h", obs(), e); end
        tick = 1'b1;
        k = 0;
        while (fallo[1] !== 1'b1 && k < T_MAX_ON + 20) begin cyc(1); k++; end
        n_vec++;
        if (k < T_MAX_ON || k > T_MAX_ON + 2) begin
            n_err++; $display("FAIL fault_latency: fault after %0d ticks, want %0d..%0d", k, T_MAX_ON, T_MAX_ON + 2);
        end
        sbq.push_back(mk(4'b0000, 4'b0010, 1, 1'b0));
        e = sbq.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL fault_outputs: got %h want %h", obs(), e); end
        n_vec++;
        if (alarma !== ALARM_ON) begin n_err++; $display("FAIL fault_alarma: got %b want %b", alarma, ALARM_ON); end
        ack_fallo = 1'b1;
        sbq.push_back(mk(4'b0000, 4'b0000, 1, 1'b0));
        cyc(1);
        ack_fallo = 1'b0;
        e = sbq.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL fault_ack: got %h want %h", obs(), e); end
        n_vec++;
        if (alarma !== 1'b0) begin n_err++; $display("FAIL ack_alarma: got %b want 0", alarma); end
        k = 0;
        while (fallo[1] !== 1'b1 && k < T_MAX_ON + 20) begin cyc(1); k++; end
        n_vec++;
        if (fallo[1] !== 1'b1) begin n_err++; $display("FAIL refault_timeout: fallo %b after %0d cycles, want 1", fallo[1], k); end
        sample(1, 2000, 0);
        sbq.push_back(mk(4'b0000, 4'b0000, 1, 1'b0));
        e = sbq.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL fault_wet_clear: got %h want %h", obs(), e); end
        n_vec++;
        if (alarma !== ALARM_ON) begin n_err++; $display("FAIL wet_clear_alarma: got %b want %b", alarma, ALARM_ON); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rr();
        test_enable_and_reset();
        test_bad_channel();
        test_soak();
        test_fault();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/riego_multicanal.md
RIEGO_MULTICANAL -- requirements
Module: riego_multicanal

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter N_CH, default 4: number of plant channels, 1..8.
REQ-003 Parameter HUM_W, default 12: humidity sample width; a larger value means wetter soil.
REQ-004 Parameter T_MAX_ON, default 30000: maximum pump on-time, in ticks.
REQ-005 Parameter T_SOAK, default 60000: post-watering soak time, in ticks.
REQ-006 Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- tick  in  1  1-cycle 1 kHz strobe
- habilitar  in  1  global enable
- dato_valid  in  1  new sample strobe
- dato_canal  in  3  sample channel index
- dato_humedad  in  HUM_W  humidity sample
- dato_tipo  in  4  plant type
- ack_fallo  in  1  clear all faults
- activarB  out  N_CH  pump drives, one-hot or zero
- regando  out  1  any pump on
- canal_activo  out  3  granted channel index
- fallo  out  N_CH  per-channel fault flags
- alarma  out  1  alarm request

Function
REQ-007 On dato_valid with dato_canal < N_CH, the block SHALL latch humedad and tipo into that channel's registers on the same edge.
REQ-008 On dato_valid with dato_canal >= N_CH, the block SHALL ignore the sample.
REQ-009 Each channel SHALL run one FSM with the states IDLE, PEND, WATER, SOAK and FAULT.
REQ-010 IDLE->PEND SHALL occur when the stored humedad is below umbral_bajo[tipo].
REQ-011 PEND->IDLE SHALL occur when the stored humedad is at or above umbral_bajo[tipo].
REQ-012 PEND->WATER SHALL occur on the cycle that channel is granted by the arbiter.
REQ-013 WATER->SOAK SHALL occur when the stored humedad is at or above umbral_alto[tipo].
REQ-014 WATER->FAULT SHALL occur when the on-time counter reaches T_MAX_ON.
REQ-015 SOAK->IDLE SHALL occur after T_SOAK ticks; new samples are latched during SOAK but SHALL be ignored by the FSM.
REQ-016 FAULT->IDLE SHALL occur on ack_fallo, or when a new sample for that channel is at or above umbral_alto.
REQ-017 At most one channel SHALL be in WATER at any time.
REQ-018 The arbiter SHALL grant round-robin among PEND channels, one cycle after no channel is in WATER, starting its search after the last granted index.
REQ-019 activarB[i] SHALL be 1 exactly while channel i is in WATER, as a registered output.
REQ-020 regando SHALL be the OR of activarB.
REQ-021 canal_activo SHALL hold the last granted index.
REQ-022 The on-time counter SHALL clear on grant, increment on tick while in WATER, and saturate.
REQ-023 Each channel SHALL have its own soak counter, 16 bits wide, saturating.
REQ-024 When habilitar=0:
- WATER SHALL go to IDLE within one cycle, with the pump off on the next edge;
- PEND SHALL NOT be granted;
- SOAK and FAULT SHALL keep running.
REQ-025 On simultaneous events:
- on-time timeout and reaching the high threshold in the same cycle SHALL go to FAULT;
- ack_fallo and a new fault in the same cycle SHALL leave the fault set.
REQ-026 fallo[i] SHALL be 1 exactly while channel i is in FAULT.

Reset
REQ-027 On rst_n=0, all FSMs SHALL go to IDLE.
REQ-028 On rst_n=0, all counters, stored humedad and stored tipo SHALL be 0.
REQ-029 On rst_n=0, activarB, regando, canal_activo, fallo and alarma SHALL be 0, and the round-robin pointer SHALL be N_CH-1.
REQ-030 Reset asserted mid-watering SHALL drop activarB asynchronously.

Configuration
REQ-031 With RIEGO_ALARMA_EN defined, alarma SHALL set when any channel enters FAULT and SHALL clear on ack_fallo.
REQ-032 With RIEGO_ALARMA_EN defined, alarma SHALL also pulse for 500 ticks at each WATER entry.
REQ-033 Without RIEGO_ALARMA_EN, alarma SHALL be tied to 0 and no alarm logic SHALL be synthesised.

Structure
REQ-034 The shared package riego_pkg SHALL hold the channel-state enum and the threshold table, indexed by tipo.
- tipo 0: umbral_bajo 1200, umbral_alto 2000
- tipo 1: umbral_bajo 800, umbral_alto 1500
- all other tipo values: umbral_bajo 1000, umbral_alto 1800
REQ-035 The round-robin arbiter SHALL be a separate sub-module, rr_arbitro, with N_CH-bit request and one-hot grant.

Verification
REQ-036 The bench SHALL cover the following directed scenarios:
- ch2 tipo0 hum=1000 -> activarB=0100 two cycles later; hum=2000 -> SOAK, activarB=0000.
- ch0 and ch3 both hum=500 tipo1 -> ch0 waters first; after ch0 reaches 1500, ch3 is granted.
- ch1 dry, no wet sample for 30000 ticks -> fallo[1]=1, pump off, alarma=1 (macro on); ack_fallo -> both cleared.
- during SOAK, ch1 hum=100 -> no watering until 60000 ticks elapse.
- dato_canal=6 with N_CH=4 -> no state change.
- rst_n low mid-WATER -> activarB=0 immediately; habilitar=0 mid-WATER -> pump off in 1 cycle.
